// File: rtl/multi_edge_detector.sv
// Multi-channel synchronising edge detector with registered rise/fall pulses,
// sticky pending flags and saturating counters. Optional filter: EDGE_DEBOUNCE_EN.
module multi_edge_detector #(
  parameter int unsigned N_CH            = 8,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned CNT_W           = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  localparam int unsigned SEL_W          = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_CH-1:0]  in,
  input  logic [N_CH-1:0]  rise_en,
  input  logic [N_CH-1:0]  fall_en,
  input  logic [N_CH-1:0]  clear,
  input  logic [SEL_W-1:0] cnt_sel,
  output logic [N_CH-1:0]  positive_edge,
  output logic [N_CH-1:0]  negative_edge,
  output logic [N_CH-1:0]  pending,
  output logic             any_pending,
  output logic [CNT_W-1:0] cnt_out
);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be >= 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_deb
    $error("DEBOUNCE_CYCLES must be >= 1");
  end

`ifdef EDGE_DEBOUNCE_EN
  localparam int unsigned WARM = SYNC_STAGES + DEBOUNCE_CYCLES + 1;
`else
  localparam int unsigned WARM = SYNC_STAGES + 1;
`endif
  localparam int unsigned WARM_W = $clog2(WARM + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [N_CH-1:0]   sync_q [SYNC_STAGES];
  logic [N_CH-1:0]   s;
  logic [N_CH-1:0]   f;
  logic [N_CH-1:0]   prev_q;
  logic [WARM_W-1:0] warm_cnt;
  logic              warm_done;
  logic [N_CH-1:0]   ev;
  logic [N_CH-1:0]   pending_nxt;
  logic [CNT_W-1:0]  cnt_q   [N_CH];
  logic [CNT_W-1:0]  cnt_nxt [N_CH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= in;
      for (int unsigned k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

`ifdef EDGE_DEBOUNCE_EN
  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  logic [N_CH-1:0] f_q;
  logic [DB_W-1:0] run_q [N_CH];

  // f follows s only after DEBOUNCE_CYCLES consecutive disagreeing samples
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      f_q <= '0;
      for (int unsigned i = 0; i < N_CH; i++) run_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        if (s[i] != f_q[i]) begin
          if (run_q[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            f_q[i]   <= s[i];
            run_q[i] <= '0;
          end else begin
            run_q[i] <= run_q[i] + 1'b1;
          end
        end else begin
          run_q[i] <= '0;
        end
      end
    end
  end

  assign f = f_q;
`else
  assign f = s;
`endif

  assign warm_done = (warm_cnt == WARM_W'(WARM));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      warm_cnt <= '0;
    end else if (!warm_done) begin
      warm_cnt <= warm_cnt + 1'b1;
    end
  end

  // prev keeps tracking during warm-up so the first live comparison is clean
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_q        <= '0;
      positive_edge <= '0;
      negative_edge <= '0;
    end else begin
      prev_q        <= f;
      positive_edge <= warm_done ? (f & ~prev_q) : '0;
      negative_edge <= warm_done ? (~f & prev_q) : '0;
    end
  end

  assign ev          = (positive_edge & rise_en) | (negative_edge & fall_en);
  assign pending_nxt = ev | (pending & ~clear);

  always_comb begin
    for (int unsigned i = 0; i < N_CH; i++) begin
      cnt_nxt[i] = cnt_q[i];
      if (ev[i]) begin
        if (clear[i])                 cnt_nxt[i] = CNT_W'(1);
        else if (cnt_q[i] != CNT_MAX) cnt_nxt[i] = cnt_q[i] + 1'b1;
      end else if (clear[i]) begin
        cnt_nxt[i] = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending     <= '0;
      any_pending <= 1'b0;
      for (int unsigned i = 0; i < N_CH; i++) cnt_q[i] <= '0;
    end else begin
      pending     <= pending_nxt;
      any_pending <= |pending_nxt;
      for (int unsigned i = 0; i < N_CH; i++) cnt_q[i] <= cnt_nxt[i];
    end
  end

  always_comb begin
    cnt_out = '0;
    if (32'(cnt_sel) < N_CH) cnt_out = cnt_q[cnt_sel];
  end

endmodule
